// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: FSM encoding, header/checksum field
// widths and the running-checksum helper.
package program_loader_pkg;

    localparam int BYTE_W = 8;
    localparam int LEN_W  = 16;
    localparam int CSUM_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LEN_HI  = 3'd1,
        ST_LEN_LO  = 3'd2,
        ST_DATA_HI = 3'd3,
        ST_DATA_LO = 3'd4,
        ST_CHECK   = 3'd5,
        ST_DONE    = 3'd6,
        ST_ERR     = 3'd7
    } state_e;

    function automatic logic [CSUM_W-1:0] csum_next(input logic [CSUM_W-1:0] csum,
                                                    input logic [BYTE_W-1:0] data_byte);
        return csum ^ data_byte;
    endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input, instruction-memory write port and session status of the loader.
interface program_loader_if
    import program_loader_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 32
);
    logic              start;
    logic              in_valid;
    logic [BYTE_W-1:0] in_data;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              busy;
    logic              done;
    logic              error;

    modport master (
        output start, in_valid, in_data,
        input  in_ready, wr_en, wr_addr, wr_data, busy, done, error
    );

    modport slave (
        input  start, in_valid, in_data,
        output in_ready, wr_en, wr_addr, wr_data, busy, done, error
    );

endinterface

// File: rtl/program_loader.sv
// Serial program loader: parses length / words / XOR checksum from a byte stream
// and writes each word into instruction memory one cycle after its low byte.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 32,
    parameter int MEM_DEPTH = 1024
) (
    input  logic             clk,
    input  logic             rst,
    program_loader_if.slave  bus
);

    localparam logic [LEN_W:0] DEPTH_L = (LEN_W + 1)'(MEM_DEPTH);

    state_e              state_q, state_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [BYTE_W-1:0]   hi_q, hi_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [CSUM_W-1:0]   csum_q, csum_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                error_q, error_d;

    logic                in_ready_s;
    logic                xfer_s;
    logic                can_start_s;
    logic [LEN_W-1:0]    len_s;
    logic [ADDR_W-1:0]   addr_next_s;

    assign in_ready_s  = (state_q == ST_LEN_HI)  || (state_q == ST_LEN_LO) ||
                         (state_q == ST_DATA_HI) || (state_q == ST_DATA_LO) ||
                         (state_q == ST_CHECK);
    assign xfer_s      = bus.in_valid && in_ready_s;
    assign can_start_s = (state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR);
    assign addr_next_s = addr_q + ADDR_W'(1);

    // Next-state and datapath decode; a byte only moves state when it is accepted.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        hi_d      = hi_q;
        addr_d    = addr_q;
        csum_d    = csum_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        done_d    = done_q;
        error_d   = error_q;
        len_s     = {hi_q, bus.in_data};

        if (bus.start && can_start_s) begin
            state_d = ST_LEN_HI;
            done_d  = 1'b0;
            error_d = 1'b0;
            addr_d  = {ADDR_W{1'b0}};
            csum_d  = {CSUM_W{1'b0}};
        end else if (xfer_s) begin
            case (state_q)
                ST_LEN_HI: begin
                    hi_d    = bus.in_data;
                    state_d = ST_LEN_LO;
                end
                ST_LEN_LO: begin
                    len_d = len_s;
                    if ({1'b0, len_s} > DEPTH_L) begin
                        state_d = ST_ERR;
                        error_d = 1'b1;
                    end else if (len_s == {LEN_W{1'b0}}) begin
                        state_d = ST_CHECK;
                    end else begin
                        state_d = ST_DATA_HI;
                    end
                end
                ST_DATA_HI: begin
                    hi_d    = bus.in_data;
                    csum_d  = csum_next(csum_q, bus.in_data);
                    state_d = ST_DATA_LO;
                end
                ST_DATA_LO: begin
                    csum_d    = csum_next(csum_q, bus.in_data);
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_q;
                    wr_data_d = DATA_W'({hi_q, bus.in_data});
                    addr_d    = addr_next_s;
                    if (addr_next_s == ADDR_W'(len_q)) begin
                        state_d = ST_CHECK;
                    end else begin
                        state_d = ST_DATA_HI;
                    end
                end
                ST_CHECK: begin
                    if (bus.in_data == csum_q) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_ERR;
                        error_d = 1'b1;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end else begin
            state_d = state_q;
        end

        busy_d = !((state_d == ST_IDLE) || (state_d == ST_DONE) || (state_d == ST_ERR));
    end

    // State and output registers; rst aborts any session immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            len_q     <= {LEN_W{1'b0}};
            hi_q      <= {BYTE_W{1'b0}};
            addr_q    <= {ADDR_W{1'b0}};
            csum_q    <= {CSUM_W{1'b0}};
            wr_en_q   <= 1'b0;
            wr_addr_q <= {ADDR_W{1'b0}};
            wr_data_q <= {DATA_W{1'b0}};
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            hi_q      <= hi_d;
            addr_q    <= addr_d;
            csum_q    <= csum_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

    assign bus.in_ready = in_ready_s;
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.error    = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: good/bad checksum, oversize and zero length,
// stalled stream, and mid-session reset followed by a clean reload.
module tb_program_loader;
    import program_loader_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    logic [47:0] wr_log[$];

    program_loader_if #(.DATA_W(16), .ADDR_W(32)) bus ();

    program_loader #(.DATA_W(16), .ADDR_W(32), .MEM_DEPTH(1024)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Write-port monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) begin
            wr_log.push_back({bus.wr_addr, bus.wr_data});
            check_val("wr_in_session", 64'(bus.busy), 64'd1);
        end
    end

    task automatic do_start();
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        repeat (gap) @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!bus.in_ready) check_val("in_ready_timeout", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic run_stream(input logic [7:0] bytes_q[$], input int max_gap);
        wr_log.delete();
        do_start();
        foreach (bytes_q[i]) send_byte(bytes_q[i], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_good_load(input string tag);
        check_val({tag, "_nwr"}, 64'(wr_log.size()), 64'd2);
        if (wr_log.size() == 2) begin
            check_val({tag, "_wr0"}, 64'(wr_log[0]), 64'h0000_0000_1234);
            check_val({tag, "_wr1"}, 64'(wr_log[1]), 64'h0000_0001_ABCD);
        end
        check_val({tag, "_done"}, 64'(bus.done), 64'd1);
        check_val({tag, "_error"}, 64'(bus.error), 64'd0);
        check_val({tag, "_busy"}, 64'(bus.busy), 64'd0);
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_in_ready", 64'(bus.in_ready), 64'd0);
        check_val("rst_busy", 64'(bus.busy), 64'd0);
        check_val("rst_done", 64'(bus.done), 64'd0);
        check_val("rst_wr_data", 64'(bus.wr_data), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Good stream: checksum 12^34^AB^CD = 40.
        run_stream('{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40}, 0);
        check_good_load("good");

        // Same stream with wrong checksum: writes stay, error flagged.
        wr_log.delete();
        do_start();
        check_val("restart_done_clr", 64'(bus.done), 64'd0);
        check_val("restart_busy", 64'(bus.busy), 64'd1);
        foreach (wr_log[i]) check_val("restart_nowr", 64'd1, 64'd0);
        begin
            logic [7:0] s[$] = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
            foreach (s[i]) send_byte(s[i], 0);
        end
        repeat (3) @(posedge clk);
        #1;
        check_val("badck_nwr", 64'(wr_log.size()), 64'd2);
        check_val("badck_error", 64'(bus.error), 64'd1);
        check_val("badck_done", 64'(bus.done), 64'd0);

        // Length 1025 exceeds depth.
        run_stream('{8'h04, 8'h01}, 0);
        check_val("big_nwr", 64'(wr_log.size()), 64'd0);
        check_val("big_error", 64'(bus.error), 64'd1);
        check_val("big_in_ready", 64'(bus.in_ready), 64'd0);
        check_val("big_busy", 64'(bus.busy), 64'd0);

        // Zero length, good and bad checksum.
        run_stream('{8'h00, 8'h00, 8'h00}, 0);
        check_val("zero_done", 64'(bus.done), 64'd1);
        check_val("zero_error", 64'(bus.error), 64'd0);
        check_val("zero_nwr", 64'(wr_log.size()), 64'd0);
        run_stream('{8'h00, 8'h00, 8'h01}, 0);
        check_val("zerobad_error", 64'(bus.error), 64'd1);
        check_val("zerobad_done", 64'(bus.done), 64'd0);

        // Good stream with random in_valid gaps.
        run_stream('{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40}, 4);
        check_good_load("gaps");

        // Reset after the first data word.
        wr_log.delete();
        do_start();
        begin
            logic [7:0] s[$] = '{8'h00, 8'h02, 8'h12, 8'h34};
            foreach (s[i]) send_byte(s[i], 0);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hAB;
        rst = 1'b1;
        #1;
        check_val("midrst_in_ready", 64'(bus.in_ready), 64'd0);
        check_val("midrst_wr_en", 64'(bus.wr_en), 64'd0);
        check_val("midrst_busy", 64'(bus.busy), 64'd0);
        check_val("midrst_wr_addr", 64'(bus.wr_addr), 64'd0);
        check_val("midrst_wr_data", 64'(bus.wr_data), 64'd0);
        check_val("midrst_error", 64'(bus.error), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        bus.in_data = 8'hCD;
        repeat (3) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check_val("midrst_nwr", 64'(wr_log.size()), 64'd1);
        if (wr_log.size() >= 1) check_val("midrst_wr0", 64'(wr_log[0]), 64'h0000_0000_1234);
        check_val("midrst_idle_ready", 64'(bus.in_ready), 64'd0);
        check_val("midrst_idle_busy", 64'(bus.busy), 64'd0);

        run_stream('{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40}, 0);
        check_good_load("reload");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 The module SHALL have parameter DATA_W, default 16, instruction word width.
REQ-002 The module SHALL have parameter ADDR_W, default 32, write address width, matching pc width.
REQ-003 The module SHALL have parameter MEM_DEPTH, default 1024, number of instruction memory words.
REQ-004 The module SHALL have port clk, input, 1 bit: single clock; all state changes on rising edge.
REQ-005 The module SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The module SHALL have port start, input, 1 bit: begin a load session when idle.
REQ-007 The module SHALL have port in_valid, input, 1 bit: in_data holds a byte.
REQ-008 The module SHALL have port in_data, input, 8 bits: serial program byte stream.
REQ-009 The module SHALL have port in_ready, output, 1 bit: loader accepts a byte this cycle.
REQ-010 The module SHALL have port wr_en, output, 1 bit: instruction memory write strobe.
REQ-011 The module SHALL have port wr_addr, output, ADDR_W bits: instruction memory word address.
REQ-012 The module SHALL have port wr_data, output, DATA_W bits: instruction word to write.
REQ-013 The module SHALL have port busy, output, 1 bit: session in progress.
REQ-014 The module SHALL have port done, output, 1 bit: session completed with a good checksum; sticky.
REQ-015 The module SHALL have port error, output, 1 bit: bad length or bad checksum; sticky.

Function
REQ-016 A byte SHALL transfer only on a rising edge where in_valid and in_ready are both 1.
REQ-017 in_ready SHALL be combinationally 1 exactly in states LEN_HI, LEN_LO, DATA_HI, DATA_LO and CHECK.
REQ-018 The FSM states SHALL be IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK, DONE and ERR.
REQ-019 From IDLE, DONE or ERR, start=1 SHALL go to LEN_HI, clear done, error and the address counter, and set checksum to 0x00; start in any other state SHALL be ignored.
REQ-020 Stream format: length N (16 bits, high byte first), then N words (high byte first), then one checksum byte.
REQ-021 In LEN_LO, a transfer SHALL latch N and then go to ERR if N > MEM_DEPTH, to CHECK if N = 0, and to DATA_HI otherwise.
REQ-022 Each DATA_LO transfer SHALL, one cycle later, pulse wr_en for exactly 1 cycle with wr_addr = word index (0..N-1) and wr_data = {hi,lo}.
REQ-023 The address counter SHALL increment after each write; after word N-1 the FSM SHALL go to CHECK.
REQ-024 The checksum SHALL be the XOR of all data bytes only, excluding length bytes.
REQ-025 A CHECK transfer SHALL go to DONE if the byte equals the running XOR, otherwise to ERR.
REQ-026 busy SHALL be 1 in all states except IDLE, DONE and ERR.
REQ-027 wr_en SHALL never assert outside a session.
REQ-028 Stalls SHALL be allowed: in_valid low for any number of cycles SHALL hold all state.
REQ-029 Words written before an ERR SHALL remain written; there SHALL be no rollback.

Reset
REQ-030 rst SHALL force, asynchronously: state IDLE; in_ready, wr_en, busy, done and error to 0; wr_addr, wr_data and checksum to 0.
REQ-031 rst asserted mid-session SHALL abort the session, with no further wr_en after rst rises.

Structure
REQ-032 The state encoding and header and checksum field widths SHALL be defined in the shared package.
REQ-033 Everything SHALL be a single flat module; no sub-module.
REQ-034 Output wr_* SHALL connect directly to the instruction memory write port while the pipeline is held idle.

Verification
REQ-035 The bench SHALL cover: start; bytes 00 02 12 34 AB CD, then 0x40 -> writes (0,0x1234) and (1,0xABCD); done=1, error=0.
REQ-036 The bench SHALL cover: same stream with checksum 0x41 -> both writes occur; error=1, done=0.
REQ-037 The bench SHALL cover: length 0x0401 (1025 > 1024) -> ERR after LEN_LO, no wr_en, in_ready=0.
REQ-038 The bench SHALL cover: length 0, checksum 0x00 -> done=1, no writes; checksum 0x01 -> error=1.
REQ-039 The bench SHALL cover: random in_valid gaps on the REQ-035 stream -> identical writes and result.
REQ-040 The bench SHALL cover: rst after the first data word -> outputs 0, state IDLE, no second write; a fresh start then loads correctly.
